// File: rtl/mem_bus_master_pkg.sv
// Shared types and constants for the single-word memory bus initiator.
// Provides size encodings, the FSM state type and the alignment rule.
package mem_bus_pkg;

  localparam logic [1:0]  SZ_BYTE  = 2'd0;
  localparam logic [1:0]  SZ_HALF  = 2'd1;
  localparam logic [1:0]  SZ_WORD  = 2'd2;
  localparam logic [31:0] MEM_BASE = 32'h8000_0000;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_READ,
    ST_WRITE,
    ST_RELEASE,
    ST_RESP
  } state_t;

  // Size code 3 behaves as a word, so only the byte and half cases are special.
  function automatic logic isMisaligned(input logic [1:0] size, input logic [1:0] offset);
    case (size)
      SZ_BYTE: return 1'b0;
      SZ_HALF: return offset[0];
      default: return offset != 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/mem_bus_master_if.sv
// CPU-side request/response channel of the memory bus initiator.
// The CPU uses the master modport, the initiator block uses the slave modport.
interface mem_bus_master_if #(
  parameter int ADDR_W = 32
);

  logic              i_req_valid;
  logic              o_req_ready;
  logic              i_req_we;
  logic [1:0]        i_req_size;
  logic              i_req_unsigned;
  logic [ADDR_W-1:0] i_req_addr;
  logic [31:0]       i_req_wdata;
  logic              o_rsp_valid;
  logic [31:0]       o_rsp_rdata;
  logic              o_rsp_err;

  modport master (
    output i_req_valid, i_req_we, i_req_size, i_req_unsigned, i_req_addr, i_req_wdata,
    input  o_req_ready, o_rsp_valid, o_rsp_rdata, o_rsp_err
  );

  modport slave (
    input  i_req_valid, i_req_we, i_req_size, i_req_unsigned, i_req_addr, i_req_wdata,
    output o_req_ready, o_rsp_valid, o_rsp_rdata, o_rsp_err
  );

endinterface

// File: rtl/mem_bus_master_lane_align.sv
// Combinational byte-lane logic: extracts and extends load data from a bus word,
// and merges sub-word store data into a previously read word.
module mem_lane_align
  import mem_bus_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [31:0] storeData_i,
  input  logic [1:0]  offset_i,
  input  logic [1:0]  size_i,
  input  logic        unsigned_i,
  output logic [31:0] loadData_o,
  output logic [31:0] mergeData_o
);

  function automatic logic [31:0] extractLane(input logic [31:0] word, input logic [1:0] offset,
                                              input logic [1:0] size, input logic uns);
    logic [7:0]  b;
    logic [15:0] h;
    b = word[{offset, 3'b000} +: 8];
    h = offset[1] ? word[31:16] : word[15:0];
    case (size)
      SZ_BYTE: extractLane = uns ? {24'h0, b} : {{24{b[7]}}, b};
      SZ_HALF: extractLane = uns ? {16'h0, h} : {{16{h[15]}}, h};
      default: extractLane = word;
    endcase
  endfunction

  // The bus has no byte enables, so untouched lanes keep the value just read.
  function automatic logic [31:0] mergeLane(input logic [31:0] oldWord, input logic [31:0] data,
                                            input logic [1:0] offset, input logic [1:0] size);
    mergeLane = oldWord;
    case (size)
      SZ_BYTE: mergeLane[{offset, 3'b000} +: 8] = data[7:0];
      SZ_HALF: begin
        if (offset[1]) mergeLane[31:16] = data[15:0];
        else           mergeLane[15:0]  = data[15:0];
      end
      default: mergeLane = data;
    endcase
  endfunction

  assign loadData_o  = extractLane(word_i, offset_i, size_i, unsigned_i);
  assign mergeData_o = mergeLane(word_i, storeData_i, offset_i, size_i);

endmodule

// File: rtl/mem_bus_master.sv
// Load/store initiator for the shared single-word memory bus with read-modify-write
// for sub-word stores. Optional misaligned trap: define MEM_BUS_MASTER_MISALIGN_TRAP_EN.
module mem_bus_master
  import mem_bus_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              i_clk,
  input  logic              i_reset,
  mem_bus_master_if.slave   req,
  output logic [ADDR_W-1:0] o_memaddr,
  output logic              o_memread,
  inout  wire  [31:0]       b_membus
);

  state_t            state_q, state_d;
  logic              we_q, we_d;
  logic [1:0]        size_q, size_d;
  logic              uns_q, uns_d;
  logic [1:0]        offset_q, offset_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [ADDR_W-1:0] memaddr_q, memaddr_d;
  logic              memread_q, memread_d;
  logic [31:0]       busOut_q, busOut_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              err_q, err_d;
  logic              misaligned;
  logic [31:0]       loadData;
  logic [31:0]       mergeData;

`ifdef MEM_BUS_MASTER_MISALIGN_TRAP_EN
  assign misaligned = isMisaligned(req.i_req_size, req.i_req_addr[1:0]);
`else
  assign misaligned = 1'b0;
`endif

  mem_lane_align u_lane (
    .word_i      (b_membus),
    .storeData_i (wdata_q),
    .offset_i    (offset_q),
    .size_i      (size_q),
    .unsigned_i  (uns_q),
    .loadData_o  (loadData),
    .mergeData_o (mergeData)
  );

  // memread only ever falls on the way into WRITE, together with the bus data.
  always_comb begin
    state_d   = state_q;
    we_d      = we_q;
    size_d    = size_q;
    uns_d     = uns_q;
    offset_d  = offset_q;
    wdata_d   = wdata_q;
    memaddr_d = memaddr_q;
    memread_d = memread_q;
    busOut_d  = busOut_q;
    rdata_d   = rdata_q;
    err_d     = err_q;
    case (state_q)
      ST_IDLE: begin
        if (req.i_req_valid) begin
          we_d     = req.i_req_we;
          size_d   = req.i_req_size;
          uns_d    = req.i_req_unsigned;
          offset_d = req.i_req_addr[1:0];
          wdata_d  = req.i_req_wdata;
          rdata_d  = 32'h0;
          err_d    = 1'b0;
          if (misaligned) begin
            err_d   = 1'b1;
            state_d = ST_RESP;
          end else begin
            memaddr_d = {req.i_req_addr[ADDR_W-1:2], 2'b00};
            if (req.i_req_we && req.i_req_size[1]) begin
              busOut_d  = req.i_req_wdata;
              memread_d = 1'b0;
              state_d   = ST_WRITE;
            end else begin
              state_d = ST_READ;
            end
          end
        end
      end
      ST_READ: begin
        if (we_q) begin
          busOut_d  = mergeData;
          memread_d = 1'b0;
          state_d   = ST_WRITE;
        end else begin
          rdata_d = loadData;
          state_d = ST_RESP;
        end
      end
      ST_WRITE: begin
        memread_d = 1'b1;
        state_d   = ST_RELEASE;
      end
      ST_RELEASE: state_d = ST_RESP;
      ST_RESP:    state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // Reset drops any transaction in flight and hands the bus back to memory.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q   <= ST_IDLE;
      we_q      <= 1'b0;
      size_q    <= SZ_BYTE;
      uns_q     <= 1'b0;
      offset_q  <= 2'b00;
      wdata_q   <= 32'h0;
      memaddr_q <= '0;
      memread_q <= 1'b1;
      busOut_q  <= 32'h0;
      rdata_q   <= 32'h0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      we_q      <= we_d;
      size_q    <= size_d;
      uns_q     <= uns_d;
      offset_q  <= offset_d;
      wdata_q   <= wdata_d;
      memaddr_q <= memaddr_d;
      memread_q <= memread_d;
      busOut_q  <= busOut_d;
      rdata_q   <= rdata_d;
      err_q     <= err_d;
    end
  end

  assign req.o_req_ready = (state_q == ST_IDLE);
  assign req.o_rsp_valid = (state_q == ST_RESP);
  assign req.o_rsp_rdata = rdata_q;
  assign req.o_rsp_err   = err_q;
  assign o_memaddr       = memaddr_q;
  assign o_memread       = memread_q;
  assign b_membus        = memread_q ? {32{1'bz}} : busOut_q;

endmodule

// File: doc/mem_bus_master.md
# mem_bus_master

Core-side initiator for the single-word shared memory bus: address, read strobe, and one bidirectional 32-bit data bus. The block accepts load/store requests from the CPU datapath and turns them into bus transactions. Byte and halfword stores are done as read-modify-write, because the bus has no byte enables. It returns load data extended to 32 bits, and the memory model and top-level memory respond to it unchanged.

## Interface
- `ADDR_W`, default 32: request/bus address width.
- `i_clk`  in  1  : system clock; all state changes on the rising edge.
- `i_reset`  in  1  : **synchronous, active-high reset**; sampled on the `i_clk` rising edge.
- `i_req_valid`  in  1  : request present.
- `o_req_ready`  out  1  : block idle and able to accept.
- `i_req_we`  in  1  : 1 = store, 0 = load.
- `i_req_size`  in  2  : 0 = byte, 1 = half, 2 = word; 3 is treated as word.
- `i_req_unsigned`  in  1  : load zero-extends (LBU/LHU).
- `i_req_addr`  in  ADDR_W  : byte address.
- `i_req_wdata`  in  32  : store data, LSB-aligned.
- `o_rsp_valid`  out  1  : one-cycle response pulse.
- `o_rsp_rdata`  out  32  : extended load data; 0 for stores.
- `o_rsp_err`  out  1  : misaligned access (see Configuration).
- `o_memaddr`  out  ADDR_W  : word-aligned bus address (`{addr[ADDR_W-1:2],2'b00}`).
- `o_memread`  out  1  : 1 = memory drives bus; a falling edge commits a write.
- `b_membus`  inout  32  : driven only while `o_memread`=0, otherwise high-Z.

## Operation
- FSM states: IDLE, READ, WRITE, RELEASE, RESP.
- **IDLE**
  - `o_req_ready`=1, `o_memread`=1, bus high-Z.
  - On `i_req_valid`, latch the request.
  - Next state: READ for a load or a byte/half store; WRITE for a word store; RESP with err when misaligned.
- **READ**
  - `o_memaddr` = latched word address, `o_memread`=1.
  - `b_membus` is sampled at the end of the cycle.
  - A load extracts its lane and goes to RESP.
  - A sub-word store merges the store data into the sampled word and goes to WRITE.
- **Lane select**
  - Byte: `addr[1:0]` selects bits `[8*n+7:8*n]`.
  - Half: `addr[1]` selects `[15:0]` or `[31:16]`.
  - Sign-extend unless `i_req_unsigned` is set.
- **WRITE**
  - `o_memread`=0, and the bus is driven with the full or merged word.
  - Both signals come from registers updated on the same edge.
  - The falling edge of `o_memread` is the write commit. Go to RELEASE.
- **RELEASE**
  - `o_memread`=1 and the bus goes high-Z on the same edge. This turnaround cycle prevents contention.
  - Go to RESP.
- **RESP**
  - `o_rsp_valid`=1 for exactly one cycle. There is no backpressure.
  - `o_rsp_rdata` holds the load result; it is 0 for stores. Go to IDLE.
- `o_memaddr` holds its last value outside READ/WRITE/RELEASE.
- Requests are never accepted outside IDLE.

## Timing
- **Reset values:** state IDLE, `o_memread`=1, bus high-Z, `o_memaddr`=0, `o_rsp_valid`=0, `o_rsp_rdata`=0, `o_rsp_err`=0, `o_req_ready`=1.
- **Latency, accept edge to `o_rsp_valid` high:**
  - load: 2 cycles (READ, RESP);
  - word store: 3 cycles;
  - sub-word store: 4 cycles;
  - misaligned with trap: 1 cycle.
- **Throughput:** next accept occurs in the cycle after RESP, so back-to-back loads run one per 3 cycles.
- **Reset mid-operation:**
  - Takes effect at the next edge: `o_memread` returns to 1 and the bus is released.
  - Reset in READ: no write occurs.
  - Reset in WRITE or RELEASE: the write already committed stays committed.
  - No response is produced for the aborted request.
- `o_memread` may only fall when entering WRITE. No other path may produce a falling edge.

## Configuration
- `MEM_BUS_MASTER_MISALIGN_TRAP_EN`
  - **Defined:** a half access with `addr[0]`=1, or a word access with `addr[1:0]`≠0, does no bus activity. It goes IDLE→RESP with `o_rsp_err`=1 and `o_rsp_rdata`=0.
  - **Undefined:** low address bits are ignored. Half uses `addr[1]` only; word forces alignment. `o_rsp_err` is tied 0.

## Structure
- **Package `mem_bus_pkg`:**
  - size encodings (`SZ_BYTE`, `SZ_HALF`, `SZ_WORD`);
  - FSM state enum;
  - bus base constant `MEM_BASE = 32'h8000_0000`.
- **Sub-module `mem_lane_align`:** combinational, with two functions.
  - Extract: word + offset + size + unsigned → extended load data.
  - Merge: old word + store data + offset + size → write word.

## Test plan
- Memory word at 0x80000010 = 0x8899AABB, load byte signed at 0x80000012 → `o_rsp_rdata`=0xFFFFFF99, `o_rsp_valid` high 2 cycles after accept.
- Same word, LHU at 0x80000012 → 0x00008899; LH at 0x80000010 → 0xFFFFAABB.
- Store word 0xDEADBEEF to 0x80000020 → exactly one `o_memread` falling edge with `o_memaddr`=0x80000020; a readback load returns 0xDEADBEEF.
- Word at 0x80000030 = 0x11223344, SB 0xA5 to 0x80000031 → word becomes 0x1122A544, sequence READ-WRITE-RELEASE-RESP, no bus contention (no X on `b_membus`).
- With the macro defined, LW at 0x80000002 → `o_rsp_err`=1 one cycle after accept, `o_memread` stays 1; without the macro → word from 0x80000000.
- Assert `i_reset` during WRITE of SW 0x12345678 → next cycle `o_memread`=1, bus high-Z, no `o_rsp_valid`, memory holds 0x12345678.
